// File: rtl/sa_tile_sequencer_if.sv
// Handshake and array-control bundle between sa_tile_sequencer and its neighbours.
// master = the sequencer; slave = the job/source/array/collector side.
interface sa_tile_sequencer_if #(
    parameter int unsigned ARRAY_SIZE = 16,
    parameter int unsigned TILE_W     = 16
);
    logic                  job_valid;
    logic                  job_ready;
    logic [TILE_W-1:0]     job_tiles;
    logic                  src_valid;
    logic                  src_ready;
    logic [ARRAY_SIZE-1:0] full_w;
    logic [ARRAY_SIZE-1:0] full_i;
    logic [ARRAY_SIZE-1:0] wren_w;
    logic [ARRAY_SIZE-1:0] wren_i;
    logic                  sa_start;
    logic                  sa_clr;
    logic                  sa_done;
    logic                  res_valid;
    logic                  res_ready;
    logic [TILE_W-1:0]     res_tile;
    logic                  busy;
    logic                  job_done;
    logic                  err_timeout;

    modport master (
        input  job_valid, job_tiles, src_valid, full_w, full_i, sa_done, res_ready,
        output job_ready, src_ready, wren_w, wren_i, sa_start, sa_clr,
               res_valid, res_tile, busy, job_done, err_timeout
    );

    modport slave (
        output job_valid, job_tiles, src_valid, full_w, full_i, sa_done, res_ready,
        input  job_ready, src_ready, wren_w, wren_i, sa_start, sa_clr,
               res_valid, res_tile, busy, job_done, err_timeout
    );
endinterface

// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for the systolic array: load -> start -> run -> result -> clr per tile.
// Optional run watchdog enabled by defining SA_TIMEOUT_EN.
module sa_tile_sequencer #(
    parameter int unsigned ARRAY_SIZE  = 16,
    parameter int unsigned LOAD_BEATS  = 16,
    parameter int unsigned TILE_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    sa_tile_sequencer_if.master bus
);
    localparam int unsigned BEAT_W = $clog2(LOAD_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LOAD_BEATS - 1);

    if (ARRAY_SIZE == 0 || LOAD_BEATS == 0 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("sa_tile_sequencer: ARRAY_SIZE, LOAD_BEATS and TIMEOUT_CYC must be non-zero");
    end

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, RESULT, CLR, FIN, ABORT} state_t;

    state_t            state, state_nx;
    logic [TILE_W-1:0] tiles_q;
    logic [TILE_W-1:0] tile_idx;
    logic [BEAT_W-1:0] beat_cnt;
    logic              can_load;
    logic              beat;
    logic              last_tile;
    logic              timed_out;

    // Extra bit keeps the compare correct for job_tiles = 2^TILE_W - 1.
    assign last_tile = ({1'b0, tile_idx} + {{TILE_W{1'b0}}, 1'b1}) == {1'b0, tiles_q};

    always_comb begin
        state_nx      = state;
        can_load      = 1'b0;
        beat          = 1'b0;
        bus.job_ready = 1'b0;
        bus.src_ready = 1'b0;
        bus.wren_w    = '0;
        bus.wren_i    = '0;
        bus.sa_start  = 1'b0;
        bus.sa_clr    = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_tile  = '0;
        bus.job_done  = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                bus.job_ready = 1'b1;
                if (bus.job_valid) state_nx = (bus.job_tiles == '0) ? FIN : LOAD;
            end
            LOAD: begin
                can_load      = ~|bus.full_w & ~|bus.full_i;
                bus.src_ready = can_load;
                beat          = bus.src_valid & can_load;
                if (beat) begin
                    bus.wren_w = '1;
                    bus.wren_i = '1;
                    if (beat_cnt == LAST_BEAT) state_nx = START;
                end
            end
            START: begin
                bus.sa_start = 1'b1;
                state_nx     = RUN;
            end
            RUN: begin
                if (bus.sa_done)    state_nx = RESULT;
                else if (timed_out) state_nx = ABORT;
            end
            RESULT: begin
                bus.res_valid = 1'b1;
                bus.res_tile  = tile_idx;
                if (bus.res_ready) state_nx = CLR;
            end
            CLR: begin
                bus.sa_clr = 1'b1;
                state_nx   = last_tile ? FIN : LOAD;
            end
            ABORT: begin
                bus.sa_clr = 1'b1;
                state_nx   = FIN;
            end
            FIN: begin
                bus.job_done = 1'b1;
                state_nx     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tiles_q  <= '0;
            tile_idx <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.job_valid) begin
                tiles_q  <= bus.job_tiles;
                tile_idx <= '0;
                beat_cnt <= '0;
            end
            if (beat) beat_cnt <= beat_cnt + 1'b1;
            if (state == CLR) begin
                tile_idx <= tile_idx + 1'b1;
                beat_cnt <= '0;
            end
        end
    end

`ifdef SA_TIMEOUT_EN
    localparam int unsigned RUN_W = $clog2(TIMEOUT_CYC + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             err_q;

    // Counter idles at zero outside RUN, so it is already cleared on RUN entry.
    assign timed_out       = (run_cnt == RUN_W'(TIMEOUT_CYC - 1));
    assign bus.err_timeout = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;
            if (state == RUN && !bus.sa_done && timed_out) err_q <= 1'b1;
        end
    end
`else
    assign timed_out       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Self-checking bench for sa_tile_sequencer: directed plan steps plus randomized jobs
// against an event/timestamp reference model of the per-tile protocol.
module tb_sa_tile_sequencer;
    localparam int unsigned N  = 16;
    localparam int unsigned LB = 16;
    localparam int unsigned TW = 16;
    localparam int unsigned TO = 64;
    localparam logic [N-1:0] ONES = '1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    int p_valid, p_full, p_rdy, lat_lo, lat_hi, stall_at, rdy_low, rst_at;
    bit poke_job, timeout_mode;

    sa_tile_sequencer_if #(.ARRAY_SIZE(N), .TILE_W(TW)) bus ();

    sa_tile_sequencer #(
        .ARRAY_SIZE (N),
        .LOAD_BEATS (LB),
        .TILE_W     (TW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.job_valid = 1'b0;
        bus.job_tiles = '0;
        bus.src_valid = 1'b0;
        bus.full_w    = '0;
        bus.full_i    = '0;
        bus.sa_done   = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    task automatic set_defaults();
        p_valid = 100; p_full = 0; p_rdy = 100; lat_lo = 20; lat_hi = 20;
        stall_at = -1; rdy_low = 0; rst_at = -1; poke_job = 0; timeout_mode = 0;
    endtask

    // Checks the quiescent IDLE output set for one cycle.
    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_job_ready"}, bus.job_ready, 1);
        chk({tag, "_busy"},      bus.busy, 0);
        chk({tag, "_src_ready"}, bus.src_ready, 0);
        chk({tag, "_wren_w"},    bus.wren_w, '0);
        chk({tag, "_wren_i"},    bus.wren_i, '0);
        chk({tag, "_sa_start"},  bus.sa_start, 0);
        chk({tag, "_sa_clr"},    bus.sa_clr, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_job_done"},  bus.job_done, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int unsigned tiles, input int budget);
        int cyc = 0, beats = 0, tile = 0, stall_rem = 0, res_cnt = 0;
        int start_due = -1, clr_due = -1, done_due = -1, done_at = -1;
        int res_from = -1, err_from = -1, start_cyc = -1;
        int starts = 0, clrs = 0, dones = 0;
        int exp_cnt;
        bit loading = 0, running = 0, res_active = 0, beat, finished = 0;

        bus.job_valid = 1'b1;
        bus.job_tiles = TW'(tiles);
        @(negedge clk);
        chk("accept_ready", bus.job_ready, 1);
        @(posedge clk); #1;
        bus.job_valid = 1'b0;
        bus.job_tiles = '0;
        cyc = 1;
        if (tiles == 0) done_due = 1; else loading = 1;

        while (!finished && cyc < budget) begin
            if (rst_at >= 0 && loading && beats == rst_at) begin
                rst_n = 1'b0;
                bus.src_valid = 1'b1;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_idle("mid_reset");
                chk("mid_reset_err", bus.err_timeout, 0);
                idle_inputs();
                return;
            end

            bus.src_valid = ($urandom_range(99) < p_valid);
            if (stall_rem > 0) begin
                bus.full_w = N'(1) << 3;
                bus.full_i = '0;
                stall_rem--;
            end else begin
                bus.full_w = ($urandom_range(99) < p_full) ? (N'(1) << $urandom_range(N - 1)) : '0;
                bus.full_i = ($urandom_range(99) < p_full) ? (N'(1) << $urandom_range(N - 1)) : '0;
            end
            bus.sa_done = running ? (cyc == done_at) : ($urandom_range(99) < 5);
            if (res_active && cyc < res_from + rdy_low) bus.res_ready = 1'b0;
            else if (rdy_low > 0)                       bus.res_ready = 1'b1;
            else                                        bus.res_ready = ($urandom_range(99) < p_rdy);
            bus.job_valid = poke_job && running && (cyc == start_cyc + 2);
            bus.job_tiles = bus.job_valid ? TW'(5) : '0;

            @(negedge clk);
            beat = bus.src_valid && bus.src_ready;
            chk("busy",       bus.busy, 1);
            chk("job_ready",  bus.job_ready, 0);
            chk("src_ready",  bus.src_ready, loading && !(|bus.full_w) && !(|bus.full_i));
            chk("wren_w",     bus.wren_w, beat ? ONES : '0);
            chk("wren_i",     bus.wren_i, beat ? ONES : '0);
            chk("sa_start",   bus.sa_start, cyc == start_due);
            chk("sa_clr",     bus.sa_clr, cyc == clr_due);
            chk("res_valid",  bus.res_valid, res_active && cyc >= res_from);
            chk("job_done",   bus.job_done, cyc == done_due);
            chk("mutex",      (bus.sa_start + bus.sa_clr + bus.src_ready) <= 1, 1);
`ifdef SA_TIMEOUT_EN
            chk("err_timeout", bus.err_timeout, err_from >= 0 && cyc >= err_from);
`else
            chk("err_timeout", bus.err_timeout, 0);
`endif

            if (beat) begin
                beats++;
                if (stall_at >= 0 && tile == 0 && beats == stall_at + 1) stall_rem = 5;
                if (beats == LB) begin
                    loading   = 0;
                    start_due = cyc + 1;
                end
            end
            if (bus.sa_start) begin
                starts++;
                running   = 1;
                start_cyc = cyc;
                if (timeout_mode) begin
                    clr_due  = cyc + 1 + TO;
                    err_from = cyc + 1 + TO;
                end else begin
                    done_at = cyc + int'($urandom_range(lat_hi, lat_lo));
                end
            end
            if (running && bus.sa_done) begin
                running    = 0;
                res_active = 1;
                res_from   = cyc + 1;
                res_cnt    = 0;
            end
            if (bus.res_valid) begin
                res_cnt++;
                chk("res_tile", bus.res_tile, tile);
                if (bus.res_ready) begin
                    res_active = 0;
                    clr_due    = cyc + 1;
                    if (rdy_low > 0) chk("res_hold_len", res_cnt, rdy_low + 1);
                end
            end
            if (bus.sa_clr) begin
                clrs++;
                running = 0;
                if (timeout_mode || tile + 1 == int'(tiles)) begin
                    done_due = cyc + 1;
                end else begin
                    tile++;
                    beats   = 0;
                    loading = 1;
                end
            end
            if (bus.job_done) begin
                dones++;
                finished = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end

        idle_inputs();
        exp_cnt = timeout_mode ? 1 : int'(tiles);
        chk("job_finished", finished, 1);
        chk("start_count",  starts, exp_cnt);
        chk("clr_count",    clrs, exp_cnt);
        chk("done_count",   dones, 1);
        if (finished) check_idle("post_job");
    endtask

    initial begin
        idle_inputs();
        set_defaults();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        chk("reset_err", bus.err_timeout, 0);
        rst_n = 1'b1;

        // Zero-tile job: accept -> FIN -> IDLE.
        run_job(0, 20);

        // Two tiles, free-flowing source and collector, 20-cycle array run.
        run_job(2, 200);

        // full_w[3] stalls the load for 5 cycles after beat 7.
        stall_at = 7;
        run_job(1, 200);
        set_defaults();

        // Collector holds off for 10 cycles after RESULT entry.
        rdy_low = 10;
        run_job(1, 200);
        set_defaults();

        // job_valid poked while running must be ignored.
        poke_job = 1;
        run_job(1, 200);
        set_defaults();

        // Reset during load beat 5, then a fresh job starts from beat 0, tile 0.
        rst_at = 5;
        run_job(1, 200);
        set_defaults();
        run_job(1, 200);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int unsigned t;
            p_valid = int'($urandom_range(100, 30));
            p_full  = int'($urandom_range(30, 0));
            p_rdy   = int'($urandom_range(100, 20));
            lat_lo  = 1;
            lat_hi  = 25;
            t = $urandom_range(3, 0);
            run_job(t, 500 * int'(t) + 50);
        end
        set_defaults();

`ifdef SA_TIMEOUT_EN
        // Array never finishes: watchdog aborts the job after the first tile's run.
        timeout_mode = 1;
        run_job(2, 300);
        set_defaults();
        check_idle("after_timeout");
        chk("err_sticky", bus.err_timeout, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle("timeout_reset");
        chk("err_cleared", bus.err_timeout, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
